remote_link_rx: RTL
===================

# remote_link_rx

Fan/player-side receiver for the remote-control link driven by the remote board (keypad speed, song select, pause toggle, DIP mode). It resynchronises the asynchronous parallel command bus and the request line, and accepts a frame only after the bus has been stable for a programmable settle time. It completes a four-phase request/acknowledge handshake back to the remote and presents registered command fields plus change strobes to the fan-motor and music-player logic.

## Interface
- STABLE_CYCLES, 8: consecutive identical synchronised samples required before a frame is latched (≥1).
- TIMEOUT_CYCLES, 1000000: SETTLE cycles before a frame is abandoned (only with timeout enabled).
- CNT_W, 8: width of the accepted-frame counter.
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- data_request  in  1  remote request, asynchronous
- speed_in  in  2  fan speed code, asynchronous
- song_sel_in  in  3  song index, asynchronous
- pause_in  in  1  pause level, asynchronous
- dip_in  in  1  mode DIP level, asynchronous
- data_ack  out  1  acknowledge to remote
- speed  out  2  accepted speed
- song_sel  out  3  accepted song index
- pause  out  1  accepted pause level
- dip  out  1  accepted DIP level
- cmd_valid  out  1  one-cycle pulse, frame latched
- speed_chg, song_chg, pause_chg  out  1 each  one-cycle pulses coincident with cmd_valid when that field differs from its previous accepted value
- frame_err  out  1  one-cycle pulse on timeout
- frame_cnt  out  CNT_W  accepted frames, wraps

## Operation
- All 8 async inputs pass through a 2-FF synchroniser; only synchronised copies are used.
- FSM states: IDLE, SETTLE, ACK, RELEASE.
- IDLE: data_ack=0. Synchronised req=1 → SETTLE, stability counter cleared, reference sample = current bus.
- SETTLE: each cycle compare bus with reference; mismatch → reference updated, counter cleared; match → counter+1. Counter reaching STABLE_CYCLES → latch fields, pulse cmd_valid and change flags, frame_cnt+1, → ACK. req drops before latch → IDLE, nothing latched.
- ACK: data_ack=1; hold until synchronised req=0 → RELEASE.
- RELEASE: data_ack=0 for one cycle, → IDLE (guarantees minimum ack-low time).
- Change flags compare against registered outputs before update; first frame after reset compares against reset values.
- frame_cnt wraps 2^CNT_W−1 → 0 silently.
- Reset mid-handshake: all outputs to reset values immediately; FSM IDLE; if remote still holds req, a new frame starts after the synchroniser refills.

## Timing
- Reset values: data_ack=0, speed=0, song_sel=0, pause=0, dip=0, all pulses 0, frame_cnt=0, state IDLE.
- req edge to IDLE exit: 2 cycles (synchroniser) + 1.
- Stable bus: cmd_valid asserted STABLE_CYCLES cycles after entering SETTLE; fields update on the same edge as cmd_valid; data_ack rises the following cycle.
- req fall to data_ack fall: 3 cycles (2 sync + ACK exit), then ≥1 cycle RELEASE before a new request is seen.
- Bus change on the same cycle the counter would hit STABLE_CYCLES: mismatch wins, counter restarts.
- Pulses are exactly one cycle; never asserted outside the latch cycle (frame_err excepted).

## Configuration
- REMOTE_RX_TIMEOUT_EN defined: timeout counter active in SETTLE; reaching TIMEOUT_CYCLES → frame_err pulse, no latch, no ack, → RELEASE then wait in IDLE only after req=0 (re-arm requires req low).
- Undefined: no timeout logic; SETTLE waits indefinitely; frame_err tied 0; TIMEOUT_CYCLES ignored.

## Structure
- Shared package remote_link_pkg: state enum, field widths (SPEED_W=2, SONG_W=3), packed bus layout {dip, pause, song_sel, speed} with bit-position constants, speed code constants shared with fsm_fan_speed.
- One sub-module: sync_2ff, parameterised width, async active-low reset to 0.

## Test plan
- Reset, req=1 with bus speed=2, song=5, pause=1, dip=0 held stable → cmd_valid after 2+1+8 cycles, outputs 2/5/1/0, speed_chg/song_chg/pause_chg=1, data_ack next cycle, frame_cnt=1.
- Same frame repeated after full handshake → cmd_valid=1, all change flags 0, frame_cnt=2.
- Toggle speed_in every 5 cycles while req=1 (STABLE_CYCLES=8) → no cmd_valid; stop toggling at speed=3 → latch 8 cycles later with speed=3.
- req dropped in SETTLE at counter=4 → back to IDLE, outputs unchanged, data_ack stays 0.
- REMOTE_RX_TIMEOUT_EN, TIMEOUT_CYCLES=50, bus toggling continuously → frame_err single pulse at cycle 50 of SETTLE, no ack; next frame only after req low then high.
- rst_n asserted during ACK → data_ack and all outputs 0 asynchronously; 255 frames then one more with CNT_W=8 → frame_cnt wraps to 0.

Source files
------------

// File: rtl/remote_link_pkg.sv
// Shared definitions for the remote-control link receiver: field widths,
// packed command-bus layout, speed codes and FSM state encodings.
package remote_link_pkg;

  localparam int SPEED_W = 2;
  localparam int SONG_W  = 3;
  localparam int BUS_W   = SPEED_W + SONG_W + 2;

  // Bit positions inside the packed bus {dip, pause, song_sel, speed}
  localparam int BUS_SPEED_LSB = 0;
  localparam int BUS_SONG_LSB  = BUS_SPEED_LSB + SPEED_W;
  localparam int BUS_PAUSE_BIT = BUS_SONG_LSB + SONG_W;
  localparam int BUS_DIP_BIT   = BUS_PAUSE_BIT + 1;

  // Speed codes, shared with the fan-speed FSM
  localparam logic [SPEED_W-1:0] SPEED_OFF  = 2'd0;
  localparam logic [SPEED_W-1:0] SPEED_LOW  = 2'd1;
  localparam logic [SPEED_W-1:0] SPEED_MED  = 2'd2;
  localparam logic [SPEED_W-1:0] SPEED_HIGH = 2'd3;

  // Receiver FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef struct packed {
    logic              dip;
    logic              pause;
    logic [SONG_W-1:0] song_sel;
    logic [SPEED_W-1:0] speed;
  } cmd_bus_t;

  // Assemble the command bus in its canonical bit order
  function automatic cmd_bus_t pack_bus(input logic [SPEED_W-1:0] speed,
                                        input logic [SONG_W-1:0]  song_sel,
                                        input logic               pause,
                                        input logic               dip);
    cmd_bus_t b;
    b.speed    = speed;
    b.song_sel = song_sel;
    b.pause    = pause;
    b.dip      = dip;
    return b;
  endfunction

endpackage

// File: rtl/remote_link_rx_sync_2ff.sv
// Two-flop synchroniser for a bundle of asynchronous level signals.
// Both stages clear to 0 on reset so a held request is re-seen only after refill.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two back-to-back capture stages to resolve metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/remote_link_rx.sv
// Remote-control link receiver: synchronises the remote's request and command
// bus, waits for the bus to settle, latches the fields and completes a
// four-phase req/ack handshake.
// Optional feature macro: REMOTE_RX_TIMEOUT_EN (abandon a frame whose bus never
// settles within TIMEOUT_CYCLES, pulse frame_err, re-arm only after req low).
module remote_link_rx #(
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_request,
  input  logic [1:0]       speed_in,
  input  logic [2:0]       song_sel_in,
  input  logic             pause_in,
  input  logic             dip_in,
  output logic             data_ack,
  output logic [1:0]       speed,
  output logic [2:0]       song_sel,
  output logic             pause,
  output logic             dip,
  output logic             cmd_valid,
  output logic             speed_chg,
  output logic             song_chg,
  output logic             pause_chg,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  import remote_link_pkg::*;

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  // Synchronised request and command bus
  logic [BUS_W:0] w_async;
  logic [BUS_W:0] w_sync;
  logic           w_req;
  cmd_bus_t       w_bus;

  assign w_async = {data_request, pack_bus(speed_in, song_sel_in, pause_in, dip_in)};

  sync_2ff #(.W(BUS_W + 1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_async),
    .o_q   (w_sync)
  );

  assign w_req = w_sync[BUS_W];
  assign w_bus = cmd_bus_t'(w_sync[BUS_W-1:0]);

  // FSM and datapath registers
  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  cmd_bus_t           r_ref;
  logic               r_data_ack;
  logic [SPEED_W-1:0] r_speed;
  logic [SONG_W-1:0]  r_song_sel;
  logic               r_pause;
  logic               r_dip;
  logic               r_cmd_valid;
  logic               r_speed_chg;
  logic               r_song_chg;
  logic               r_pause_chg;
  logic               r_frame_err;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic [1:0] w_nxt_state;
  logic       w_match;
  logic       w_latch;
  logic       w_timeout;
  logic       w_tmo_hit;
  logic       w_armed;

  assign w_match = (w_bus == r_ref);

`ifdef REMOTE_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmr;
  logic          r_armed;

  // Count cycles spent in SETTLE; cleared in every other state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_tmr <= r_tmr + TW'(1);
    end else begin
      r_tmr <= '0;
    end
  end

  // After a timeout, ignore the still-high request until the remote drops it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
    end else if (w_timeout) begin
      r_armed <= 1'b0;
    end else if ((r_state == ST_IDLE) && !w_req) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= r_armed;
    end
  end

  assign w_tmo_hit = (r_state == ST_SETTLE) && (r_tmr == TW'(TIMEOUT_CYCLES - 1));
  assign w_armed   = r_armed;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
  assign w_armed      = 1'b1;
`endif

  // Next-state decode; a mismatch on the would-be latch cycle restarts settling
  always_comb begin
    w_nxt_state = r_state;
    w_latch     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && w_armed) begin
          w_nxt_state = ST_SETTLE;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!w_req) begin
          w_nxt_state = ST_IDLE;
        end else if (w_match && (r_cnt == STABLE_LAST)) begin
          w_latch     = 1'b1;
          w_nxt_state = ST_ACK;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_nxt_state = ST_RELEASE;
        end else begin
          w_nxt_state = ST_SETTLE;
        end
      end
      ST_ACK: begin
        if (!w_req) begin
          w_nxt_state = ST_RELEASE;
        end else begin
          w_nxt_state = ST_ACK;
        end
      end
      ST_RELEASE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State, stability counter, reference sample and acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ref      <= '0;
      r_data_ack <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      // ack rises the cycle after the latch and drops on the ACK exit edge
      r_data_ack <= (r_state == ST_ACK) && w_req;
      if ((r_state == ST_SETTLE) && w_match) begin
        r_cnt <= r_cnt + CW'(1);
        r_ref <= r_ref;
      end else begin
        r_cnt <= '0;
        r_ref <= w_bus;
      end
    end
  end

  // Latch accepted fields, change strobes and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed     <= SPEED_OFF;
      r_song_sel  <= '0;
      r_pause     <= 1'b0;
      r_dip       <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_speed_chg <= 1'b0;
      r_song_chg  <= 1'b0;
      r_pause_chg <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_frame_err <= w_timeout;
      if (w_latch) begin
        r_cmd_valid <= 1'b1;
        r_speed_chg <= (w_bus.speed != r_speed);
        r_song_chg  <= (w_bus.song_sel != r_song_sel);
        r_pause_chg <= (w_bus.pause != r_pause);
        r_speed     <= w_bus.speed;
        r_song_sel  <= w_bus.song_sel;
        r_pause     <= w_bus.pause;
        r_dip       <= w_bus.dip;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end else begin
        r_cmd_valid <= 1'b0;
        r_speed_chg <= 1'b0;
        r_song_chg  <= 1'b0;
        r_pause_chg <= 1'b0;
      end
    end
  end

  assign data_ack  = r_data_ack;
  assign speed     = r_speed;
  assign song_sel  = r_song_sel;
  assign pause     = r_pause;
  assign dip       = r_dip;
  assign cmd_valid = r_cmd_valid;
  assign speed_chg = r_speed_chg;
  assign song_chg  = r_song_chg;
  assign pause_chg = r_pause_chg;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;

endmodule
